uart_alu_bridge: RTL and testbench
==================================

Name: uart_alu_bridge

Overview:
- Sequential front-end sitting directly upstream of the combinational ALU (NB_DATA=8, NB_OP=6) and directly downstream of the UART receiver.
- Assembles a 3-byte frame from the UART RX byte stream, in the order operand A, operand B, opcode.
- Drives the ALU with that frame, latches its result, and hands the result byte to the UART TX with a start/done handshake.
- Resynchronises on a per-byte timeout and rejects opcodes the ALU does not implement.

Parameters:
- NB_DATA, 8, width of operands, result and UART bytes.
- NB_OP, 6, ALU opcode width; the opcode is taken from the low NB_OP bits of the third byte.
- TIMEOUT, 1000000, maximum idle clock cycles allowed between bytes of one frame (32-bit counter).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse per received byte.
- i_alu_result  in  NB_DATA  ALU o_data (combinational from the o_alu_* ports).
- o_alu_data_a  out  NB_DATA  registered operand A to the ALU.
- o_alu_data_b  out  NB_DATA  registered operand B to the ALU.
- o_alu_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  result byte to UART TX; held stable until the next frame.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- i_tx_done  in  1  one-cycle pulse from UART TX when the byte has been sent.
- o_busy  out  1  high in every state except IDLE.
- o_op_error  out  1  one-cycle pulse when an invalid opcode is received.
- o_timeout  out  1  one-cycle pulse when a partial frame is abandoned.
- o_overrun  out  1  one-cycle pulse when an RX byte is dropped.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State goes to IDLE.
  - o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data go to 0.
  - o_tx_start, o_op_error, o_timeout, o_overrun go to 0; o_busy is 0.
  - Timeout counter goes to 0.
  - Reset overrides every other input on the same edge, including mid-frame and during WAIT_TX.
- States: IDLE, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- IDLE:
  - On i_rx_done: o_alu_data_a <= i_rx_data, go to WAIT_B.
- WAIT_B:
  - On i_rx_done: o_alu_data_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP:
  - On i_rx_done, if the low NB_OP bits are a valid code: o_alu_op <= those bits, go to EXEC.
  - On i_rx_done with an invalid code: pulse o_op_error, go to IDLE, o_alu_op unchanged.
  - Upper byte bits are ignored.
- Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
- EXEC (exactly one cycle):
  - o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
  - Latency: op byte sampled on edge k; o_tx_start is high for exactly the cycle after edge k+1.
- WAIT_TX:
  - o_tx_start returns to 0 on the first edge.
  - On i_tx_done: go to IDLE.
  - i_tx_done in any other state is ignored.
- Timeout:
  - The counter clears on entry to WAIT_B/WAIT_OP and on every accepted byte.
  - It increments each cycle spent in WAIT_B or WAIT_OP without i_rx_done.
  - When it reaches TIMEOUT: go to IDLE, pulse o_timeout, clear the counter; captured operands are kept but are stale.
  - The counter is inactive in IDLE, EXEC and WAIT_TX.
- Overrun:
  - i_rx_done during EXEC or WAIT_TX drops the byte, pulses o_overrun, and leaves the state unchanged.
- Simultaneous i_rx_done and timeout expiry in the same cycle: the byte wins and the counter clears.
- Arithmetic: none inside this block; the result is passed through unmodified from the ALU.

Test Plan:
- ADD: bytes 0x0A, 0x0F, 0x20 → o_alu_op=6'b100000, o_tx_start pulse 2 cycles after the op byte, o_tx_data=0x19; i_tx_done returns to IDLE with o_busy=0.
- SUB, then SRA back-to-back:
  - 0x14, 0x05, 0x22 → tx 0x0F.
  - After i_tx_done: 0xAA, 0x00, 0x03 → tx 0xD5.
- Invalid op: 0x01, 0x02, 0x3F → one o_op_error pulse, no o_tx_start, state IDLE.
  - Next frame 0x01, 0x02, 0x20 → tx 0x03.
- Timeout (TIMEOUT=16): byte 0x05, then silence → o_timeout pulse on the 16th idle cycle, IDLE.
  - Next frame 0x03, 0x04, 0x20 → tx 0x07.
- Overrun: send byte 0x77 while in WAIT_TX → o_overrun pulse, o_tx_data unchanged.
  - After i_tx_done the next 3 bytes form a fresh frame.
- Reset mid-frame: after bytes 0x11, 0x22, assert i_reset for one cycle → all outputs 0, IDLE.
  - Frame 0xF0, 0x0F, 0x25 → tx 0xFF.

Source files
------------

// File: rtl/uart_alu_bridge.sv
// Frame assembler between the UART receiver and the combinational ALU.
// Collects A, B, opcode bytes, runs the ALU for one cycle and hands the result to UART TX.
module uart_alu_bridge #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_OP, EXEC, WAIT_TX} state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [31:0]       tmo_cnt;
  logic [NB_OP-1:0]  rx_op;
  logic              tmo_hit, cnt_run;
  logic              load_a, load_b, load_op, do_exec;
  logic              op_err, tmo_fire, ovr;
  logic              unused_rx_hi;

  assign rx_op        = i_rx_data[NB_OP-1:0];
  assign unused_rx_hi = ^i_rx_data[NB_DATA-1:NB_OP];
  assign tmo_hit      = (tmo_cnt == TMO_LAST);
  assign o_busy       = (state != IDLE);

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
      NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
      NB_OP'(6'b000010), NB_OP'(6'b000011): op_valid = 1'b1;
      default:                               op_valid = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    do_exec    = 1'b0;
    op_err     = 1'b0;
    tmo_fire   = 1'b0;
    ovr        = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          if (op_valid(rx_op)) begin
            load_op    = 1'b1;
            state_next = EXEC;
          end else begin
            op_err     = 1'b1;
            state_next = IDLE;
          end
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      EXEC: begin
        do_exec    = 1'b1;
        ovr        = i_rx_done;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        ovr = i_rx_done;
        if (i_tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter only runs while a partial frame waits; any byte or expiry clears it.
  assign cnt_run = ((state == WAIT_B) || (state == WAIT_OP)) && !i_rx_done && !tmo_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_op_error   <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      tmo_cnt    <= cnt_run ? tmo_cnt + 32'd1 : 32'd0;
      o_tx_start <= do_exec;
      o_op_error <= op_err;
      o_timeout  <= tmo_fire;
      o_overrun  <= ovr;
      if (load_a)  o_alu_data_a <= i_rx_data;
      if (load_b)  o_alu_data_b <= i_rx_data;
      if (load_op) o_alu_op     <= rx_op;
      if (do_exec) o_tx_data    <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Directed bench for uart_alu_bridge with a small behavioural ALU closing the loop.
module tb_uart_alu_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_data_a, alu_data_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, tx_done, busy, op_error, timeout, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_alu_bridge #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_alu_result(alu_result), .o_alu_data_a(alu_data_a), .o_alu_data_b(alu_data_b),
    .o_alu_op(alu_op), .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_op_error(op_error), .o_timeout(timeout), .o_overrun(overrun)
  );

  // ALU stand-in; shifts move operand A by one place.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      6'b100000: alu_result = alu_data_a + alu_data_b;
      6'b100010: alu_result = alu_data_a - alu_data_b;
      6'b100100: alu_result = alu_data_a & alu_data_b;
      6'b100101: alu_result = alu_data_a | alu_data_b;
      6'b100110: alu_result = alu_data_a ^ alu_data_b;
      6'b100111: alu_result = ~(alu_data_a | alu_data_b);
      6'b000010: alu_result = {1'b0, alu_data_a[7:1]};
      6'b000011: alu_result = {alu_data_a[7], alu_data_a[7:1]};
      default:   alu_result = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_a"},     32'(alu_data_a), 32'h0);
    chk({tag, "_b"},     32'(alu_data_b), 32'h0);
    chk({tag, "_op"},    32'(alu_op),     32'h0);
    chk({tag, "_txd"},   32'(tx_data),    32'h0);
    chk({tag, "_flags"}, 32'({tx_start, busy, op_error, timeout, overrun}), 32'h0);
  endtask

  // Full frame up to the TX start pulse; leaves the DUT in WAIT_TX.
  task automatic frame_to_tx(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [5:0] exp_op,
                             input logic [7:0] exp_res);
    send_byte(a);
    chk({tag, "_a"}, 32'(alu_data_a), 32'(a));
    chk({tag, "_busy_b"}, 32'(busy), 32'h1);
    send_byte(b);
    chk({tag, "_b"}, 32'(alu_data_b), 32'(b));
    send_byte(op);
    chk({tag, "_op"}, 32'(alu_op), 32'(exp_op));
    chk({tag, "_start_early"}, 32'(tx_start), 32'h0);
    tick();
    chk({tag, "_start"}, 32'(tx_start), 32'h1);
    chk({tag, "_txd"}, 32'(tx_data), 32'(exp_res));
    tick();
    chk({tag, "_start_drop"}, 32'(tx_start), 32'h0);
    chk({tag, "_busy_tx"}, 32'(busy), 32'h1);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [5:0] exp_op,
                            input logic [7:0] exp_res);
    frame_to_tx(tag, a, b, op, exp_op, exp_res);
    pulse_tx_done();
    chk({tag, "_idle"}, 32'(busy), 32'h0);
    chk({tag, "_txd_hold"}, 32'(tx_data), 32'(exp_res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    pulse_tx_done();
    chk("txdone_in_idle", 32'(busy), 32'h0);

    full_frame("add", 8'h0A, 8'h0F, 8'h20, 6'b100000, 8'h19);
    full_frame("sub", 8'h14, 8'h05, 8'h22, 6'b100010, 8'h0F);
    full_frame("sra", 8'hAA, 8'h00, 8'h03, 6'b000011, 8'hD5);

    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
    chk("inv_err", 32'(op_error), 32'h1);
    chk("inv_idle", 32'(busy), 32'h0);
    chk("inv_op_kept", 32'(alu_op), 32'(6'b000011));
    tick();
    chk("inv_err_drop", 32'(op_error), 32'h0);
    chk("inv_no_start", 32'(tx_start), 32'h0);
    full_frame("after_inv", 8'h01, 8'h02, 8'h20, 6'b100000, 8'h03);

    full_frame("nor_hi_bits", 8'h0F, 8'h30, 8'hE7, 6'b100111, 8'hC0);

    send_byte(8'h05);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", 32'(timeout), 32'h0);
    chk("tmo_busy", 32'(busy), 32'h1);
    tick();
    chk("tmo_pulse", 32'(timeout), 32'h1);
    chk("tmo_idle", 32'(busy), 32'h0);
    tick();
    chk("tmo_drop", 32'(timeout), 32'h0);
    full_frame("after_tmo", 8'h03, 8'h04, 8'h20, 6'b100000, 8'h07);

    // Late byte one cycle before expiry is accepted and restarts the count.
    send_byte(8'h09);
    for (int i = 0; i < 14; i++) tick();
    send_byte(8'h06);
    chk("tmo_rescue_b", 32'(alu_data_b), 32'h06);
    chk("tmo_rescue_flag", 32'(timeout), 32'h0);
    send_byte(8'h22);
    tick();
    chk("tmo_rescue_txd", 32'(tx_data), 32'h03);
    tick();
    pulse_tx_done();

    frame_to_tx("ovr_frame", 8'h55, 8'h0F, 8'h26, 6'b100110, 8'h5A);
    send_byte(8'h77);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_busy", 32'(busy), 32'h1);
    chk("ovr_txd", 32'(tx_data), 32'h5A);
    chk("ovr_a_kept", 32'(alu_data_a), 32'h55);
    tick();
    chk("ovr_drop", 32'(overrun), 32'h0);
    pulse_tx_done();
    chk("ovr_idle", 32'(busy), 32'h0);
    full_frame("after_ovr", 8'h3C, 8'h0F, 8'h24, 6'b100100, 8'h0C);

    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    rx_data = 8'h20;
    rx_done = 1'b1;
    tick();
    reset = 1'b0;
    rx_done = 1'b0;
    check_idle_outputs("mid_reset");
    full_frame("after_reset", 8'hF0, 8'h0F, 8'h25, 6'b100101, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
